// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin byte arbiter with packet lock in front of a UART TX core
module uart_tx_arbiter #(
  parameter int N_REQ        = 2,
  parameter int IDX_W        = 1,
  parameter int LOCK_TIMEOUT = 1000,
  parameter int TO_W         = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  input  logic [N_REQ-1:0]     req_last,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tx_ready,
  output logic [7:0]           t_data,
  output logic                 t_valid,
  output logic [IDX_W-1:0]     owner,
  output logic                 locked,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Final count value before the lock is dropped; unused when the timeout is disabled.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((LOCK_TIMEOUT > 0) ? (LOCK_TIMEOUT - 1) : 0);

  state_e            state_q;
  logic [7:0]        buf_q;
  logic              t_valid_q;
  logic [IDX_W-1:0]  owner_q;
  logic              locked_q;
  logic [IDX_W-1:0]  rr_ptr_q;
  logic [TO_W-1:0]   to_cnt_q;

  logic [IDX_W-1:0]  sel_idx;
  logic              sel_vld;
  logic [IDX_W-1:0]  rr_ptr_d;

  // Pick the requester to serve: the lock owner, or the first valid one from rr_ptr onwards.
  always_comb begin
    int idx;
    idx     = 0;
    sel_idx = owner_q;
    sel_vld = 1'b0;
    if (locked_q) begin
      sel_idx = owner_q;
      sel_vld = req_valid[owner_q];
    end else begin
      // Walk offsets from farthest to nearest so the nearest valid index wins.
      for (int j = N_REQ - 1; j >= 0; j--) begin
        idx = int'(rr_ptr_q) + j;
        if (idx >= N_REQ) begin
          idx = idx - N_REQ;
        end
        if (req_valid[idx]) begin
          sel_idx = IDX_W'(idx);
          sel_vld = 1'b1;
        end
      end
    end
  end

  // Rotation pointer resumes just past the requester being accepted.
  always_comb begin
    rr_ptr_d = sel_idx + IDX_W'(1);
    if (sel_idx == IDX_W'(N_REQ - 1)) begin
      rr_ptr_d = '0;
    end
  end

  // Ready only in IDLE and only to the selected requester; tx_ready never reaches here.
  always_comb begin
    req_ready = '0;
    if ((state_q == IDLE) && sel_vld) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  // Main FSM: accept a byte, hold it on t_data until taken, then one idle gap cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      buf_q     <= 8'h00;
      t_valid_q <= 1'b0;
      owner_q   <= '0;
      locked_q  <= 1'b0;
      rr_ptr_q  <= '0;
      to_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_vld) begin
            buf_q     <= req_data[8*sel_idx +: 8];
            owner_q   <= sel_idx;
            locked_q  <= ~req_last[sel_idx];
            rr_ptr_q  <= rr_ptr_d;
            to_cnt_q  <= '0;
            t_valid_q <= 1'b1;
            state_q   <= SEND;
          end else if (locked_q && (LOCK_TIMEOUT != 0)) begin
            // Owner is stalled mid-packet: count idle cycles and drop the lock at the limit.
            if (to_cnt_q == TO_LAST) begin
              locked_q <= 1'b0;
              to_cnt_q <= '0;
            end else begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end
          end
        end
        SEND: begin
          if (tx_ready) begin
            t_valid_q <= 1'b0;
            state_q   <= GAP;
          end
        end
        GAP: begin
          // Lets a transmitter whose tx_ready drops one cycle late settle before the next byte.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign t_data  = buf_q;
  assign t_valid = t_valid_q;
  assign owner   = owner_q;
  assign locked  = locked_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_last;
  logic [1:0]  req_ready;
  logic        tx_ready;
  logic [7:0]  t_data;
  logic        t_valid;
  logic [0:0]  owner;
  logic        locked;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] sb[$];
  int         xq[$];
  logic [8:0] s0[$];
  logic [8:0] s1[$];
  logic       exp_locked;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ(2),
    .IDX_W(1),
    .LOCK_TIMEOUT(4),
    .TO_W(16)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .tx_ready(tx_ready),
    .t_data(t_data),
    .t_valid(t_valid),
    .owner(owner),
    .locked(locked),
    .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every transfer must match the oldest expected byte.
  always @(posedge clk) begin
    #4;
    if (rstn && t_valid && tx_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL tx_unexpected got=%0h exp=none", t_data);
      end
      if (sb.size() > 0) begin
        chk("tx_data", {24'h0, t_data}, {24'h0, sb.pop_front()});
      end
      xq.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    tx_ready   = 1'b1;
    exp_locked = 1'b0;
    nxt();
    nxt();
    rstn = 1'b1;
  endtask

  // Drive both sources from their byte queues, following req_ready handshakes.
  task automatic run_src(input int bound);
    int         n;
    logic [8:0] h0;
    logic [8:0] h1;
    logic [1:0] acc;
    n = 0;
    while ((n < bound) && ((sb.size() > 0) || (s0.size() > 0) || (s1.size() > 0))) begin
      h0 = (s0.size() > 0) ? s0[0] : 9'h0;
      h1 = (s1.size() > 0) ? s1[0] : 9'h0;
      req_valid = {s1.size() > 0, s0.size() > 0};
      req_data  = {h1[7:0], h0[7:0]};
      req_last  = {h1[8], h0[8]};
      #1;
      chk("locked", {31'h0, locked}, {31'h0, exp_locked});
      acc = req_valid & req_ready;
      if (acc[0]) begin
        exp_locked = ~h0[8];
        void'(s0.pop_front());
      end
      if (acc[1]) begin
        exp_locked = ~h1[8];
        void'(s1.pop_front());
      end
      nxt();
      n++;
    end
    req_valid = '0;
    chk("src_in_time", {31'h0, n < bound}, 32'h1);
  endtask

  initial begin
    rstn      = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;

    // Reset state
    do_reset();
    #1;
    chk("rst_tvalid", {31'h0, t_valid}, 32'h0);
    chk("rst_tdata", {24'h0, t_data}, 32'h0);
    chk("rst_owner", {31'h0, owner}, 32'h0);
    chk("rst_locked", {31'h0, locked}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ready", {30'h0, req_ready}, 32'h0);

    // Single byte
    nxt();
    sb.push_back(8'h41);
    req_valid = 2'b01;
    req_data  = 16'h0041;
    req_last  = 2'b01;
    #1;
    chk("single_ready", {30'h0, req_ready}, 32'h1);
    nxt();
    req_valid = 2'b00;
    #1;
    chk("single_tvalid", {31'h0, t_valid}, 32'h1);
    chk("single_tdata", {24'h0, t_data}, 32'h41);
    chk("single_busy", {31'h0, busy}, 32'h1);
    nxt();
    #1;
    chk("gap_tvalid", {31'h0, t_valid}, 32'h0);
    chk("gap_busy", {31'h0, busy}, 32'h1);
    nxt();
    #1;
    chk("idle_busy", {31'h0, busy}, 32'h0);
    chk("idle_locked", {31'h0, locked}, 32'h0);

    // Fairness and throughput
    do_reset();
    s0 = {9'h110, 9'h110};
    s1 = {9'h111, 9'h111};
    sb = {8'h10, 8'h11, 8'h10, 8'h11};
    xq.delete();
    run_src(60);
    chk("fair_count", xq.size(), 32'd4);
    if (xq.size() == 4) begin
      for (int i = 0; i < 3; i++) begin
        chk("fair_spacing", xq[i+1] - xq[i], 32'd3);
      end
    end

    // Packet lock
    do_reset();
    s0 = {9'h0A0, 9'h0A1, 9'h1A2};
    s1 = {9'h1B0};
    sb = {8'hA0, 8'hA1, 8'hA2, 8'hB0};
    run_src(60);

    // Backpressure
    do_reset();
    tx_ready = 1'b0;
    sb.push_back(8'h55);
    req_valid = 2'b01;
    req_data  = 16'h0055;
    req_last  = 2'b01;
    #1;
    chk("bp_ready", {30'h0, req_ready}, 32'h1);
    nxt();
    req_valid = 2'b10;
    req_data  = 16'h7700;
    req_last  = 2'b10;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("bp_tvalid", {31'h0, t_valid}, 32'h1);
      chk("bp_tdata", {24'h0, t_data}, 32'h55);
      chk("bp_noready", {30'h0, req_ready}, 32'h0);
      nxt();
    end
    tx_ready  = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("bp_release_tvalid", {31'h0, t_valid}, 32'h1);
    nxt();
    #1;
    chk("bp_gap_tvalid", {31'h0, t_valid}, 32'h0);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Lock timeout expires
    do_reset();
    sb.push_back(8'h01);
    req_valid = 2'b11;
    req_data  = 16'h2201;
    req_last  = 2'b10;
    #1;
    chk("to_first_ready", {30'h0, req_ready}, 32'h1);
    nxt();
    req_valid = 2'b10;
    #1;
    chk("to_send_locked", {31'h0, locked}, 32'h1);
    nxt();
    #1;
    chk("to_gap_ready", {30'h0, req_ready}, 32'h0);
    nxt();
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("to_hold_ready", {30'h0, req_ready}, 32'h0);
      chk("to_hold_locked", {31'h0, locked}, 32'h1);
      nxt();
    end
    #1;
    chk("to_release_locked", {31'h0, locked}, 32'h0);
    chk("to_release_ready", {30'h0, req_ready}, 32'h2);
    sb.push_back(8'h22);
    nxt();
    req_valid = 2'b00;
    nxt();
    nxt();
    chk("to_sb_empty", sb.size(), 32'd0);

    // Owner returns on the last timeout cycle
    do_reset();
    sb.push_back(8'h01);
    req_valid = 2'b11;
    req_data  = 16'h2201;
    req_last  = 2'b10;
    nxt();
    req_valid = 2'b10;
    nxt();
    nxt();
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk("re_hold_ready", {30'h0, req_ready}, 32'h0);
      nxt();
    end
    req_valid = 2'b11;
    req_data  = 16'h2202;
    req_last  = 2'b10;
    sb.push_back(8'h02);
    #1;
    chk("re_owner_ready", {30'h0, req_ready}, 32'h1);
    nxt();
    #1;
    chk("re_locked", {31'h0, locked}, 32'h1);
    chk("re_owner", {31'h0, owner}, 32'h0);
    chk("re_tdata", {24'h0, t_data}, 32'h02);
    nxt();
    exp_locked = 1'b1;
    s0 = {9'h103};
    s1 = {9'h122};
    sb.push_back(8'h03);
    sb.push_back(8'h22);
    run_src(60);

    // Reset while a byte is pending
    do_reset();
    tx_ready  = 1'b0;
    req_valid = 2'b10;
    req_data  = 16'h9900;
    req_last  = 2'b00;
    #1;
    chk("mid_ready", {30'h0, req_ready}, 32'h2);
    nxt();
    req_valid = 2'b00;
    #1;
    chk("mid_tvalid", {31'h0, t_valid}, 32'h1);
    chk("mid_owner", {31'h0, owner}, 32'h1);
    chk("mid_locked", {31'h0, locked}, 32'h1);
    nxt();
    rstn = 1'b0;
    nxt();
    #1;
    chk("mid_rst_tvalid", {31'h0, t_valid}, 32'h0);
    chk("mid_rst_locked", {31'h0, locked}, 32'h0);
    chk("mid_rst_owner", {31'h0, owner}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    rstn     = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      nxt();
      #1;
      chk("mid_post_tvalid", {31'h0, t_valid}, 32'h0);
    end

    chk("final_sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
